mixer_ctrl: RTL

- Synthesizable controller that sequences the RF mixer: power-up settling, gain configuration (ota, buff) and power-down.
- Monitors the mixer IF output (1-bit sliced sign) by counting rising edges per fixed window, and flags whether the IF lies inside a programmed band.
- Sits between the SoC register interface and the mixer/IF path; drives the mixer `pd`, `ota` and `buff` pins directly.

---
 rtl/mixer_ctrl_pkg.sv | 14 +
 rtl/if_edge_counter.sv | 64 ++++++
 rtl/mixer_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mixer_ctrl_pkg.sv
// Shared types and default gain settings for the RF mixer controller.
package mixer_ctrl_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      PWRUP = 2'd1,
      MEAS  = 2'd2,
      ON    = 2'd3
   } state_t;

   localparam logic       OTA_DEFAULT  = 1'b1;
   localparam logic [1:0] BUFF_DEFAULT = 2'b01;

endpackage

// File: rtl/if_edge_counter.sv
// IF sign synchronizer, rising-edge detector and saturating per-window edge counter.
module if_edge_counter #(
   parameter int unsigned WIN_CYCLES = 1024,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             count_en,
   input  logic             if_bit,
   output logic             win_done,
   output logic [CNT_W-1:0] cnt
);

   localparam int unsigned      TW       = $clog2(WIN_CYCLES);
   localparam logic [TW-1:0]    WIN_LAST = TW'(WIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic             s1;
   logic             s2;
   logic             s3;
   logic             edge_det;
   logic [TW-1:0]    win_tmr;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= if_bit;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edge_det = s2 & ~s3;
   assign win_done = count_en && (win_tmr == WIN_LAST);

   // cnt includes the edge seen in the current cycle, so the last-cycle edge lands in the result
   always_comb begin
      cnt = cnt_q;
      if (edge_det && (cnt_q != CNT_MAX)) begin
         cnt = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         win_tmr <= '0;
         cnt_q   <= '0;
      end else if (count_en) begin
         if (win_done) begin
            win_tmr <= '0;
            cnt_q   <= '0;
         end else begin
            win_tmr <= win_tmr + 1'b1;
            cnt_q   <= cnt;
         end
      end
   end

endmodule

// File: rtl/mixer_ctrl.sv
// RF mixer sequencer: power-up settling, gain configuration handshake and IF band monitoring.
module mixer_ctrl
   import mixer_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 64,
   parameter int unsigned WIN_CYCLES    = 1024,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             cfg_ota,
   input  logic [1:0]       cfg_buff,
   input  logic [CNT_W-1:0] if_min,
   input  logic [CNT_W-1:0] if_max,
   input  logic             if_bit,
   output logic             pd,
   output logic             ota,
   output logic [1:0]       buff,
   output logic             rx_ready,
   output logic             meas_valid,
   output logic [CNT_W-1:0] meas_cnt,
   output logic             in_band
);

   localparam int unsigned   SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   logic [SW-1:0]    settle_tmr;
   logic             counting;
   logic             win_done;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= OFF;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pd         = 1'b0;
      rx_ready   = 1'b0;
      cfg_ready  = 1'b0;
      case (state)
         OFF: begin
            pd        = 1'b1;
            cfg_ready = 1'b1;
            if (en) state_next = PWRUP;
         end
         PWRUP: begin
            if (!en)                     state_next = OFF;
            else if (settle_tmr == '0)   state_next = MEAS;
         end
         MEAS: begin
            if (!en)           state_next = OFF;
            else if (win_done) state_next = ON;
         end
         ON: begin
            rx_ready  = 1'b1;
            cfg_ready = 1'b1;
            if (!en) state_next = OFF;
         end
         default: state_next = OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_tmr <= '0;
      end else if (state == OFF && en) begin
         settle_tmr <= SETTLE_LAST;
      end else if (state == PWRUP && en && settle_tmr != '0) begin
         settle_tmr <= settle_tmr - 1'b1;
      end else begin
         settle_tmr <= '0;
      end
   end

   // Dropping en gates counting in the same cycle so a coinciding window end yields no pulse
   assign counting = ((state == MEAS) || (state == ON)) && en;

   if_edge_counter #(
      .WIN_CYCLES (WIN_CYCLES),
      .CNT_W      (CNT_W)
   ) u_edge_counter (
      .clk      (clk),
      .rst      (rst),
      .clr      (!counting),
      .count_en (counting),
      .if_bit   (if_bit),
      .win_done (win_done),
      .cnt      (cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         meas_valid <= 1'b0;
         meas_cnt   <= '0;
         in_band    <= 1'b0;
      end else begin
         meas_valid <= win_done;
         if (win_done) begin
            meas_cnt <= cnt;
            in_band  <= (cnt >= if_min) && (cnt <= if_max);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ota  <= OTA_DEFAULT;
         buff <= BUFF_DEFAULT;
      end else if (cfg_valid && cfg_ready) begin
         ota  <= cfg_ota;
         buff <= cfg_buff;
      end
   end

`ifndef SYNTHESIS
   logic gain_warn_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         gain_warn_q <= 1'b0;
      end else begin
         gain_warn_q <= !pd && (ota != OTA_DEFAULT || buff != BUFF_DEFAULT);
         if (!pd && (ota != OTA_DEFAULT || buff != BUFF_DEFAULT) && !gain_warn_q) begin
            $warning("mixer_ctrl: powered with non-default gain ota=%0b buff=%02b", ota, buff);
         end
      end
   end
`endif

endmodule
